prbs_descrambler: RTL and testbench

PRBS_DESCRAMBLER -- requirements
Module: prbs_descrambler

---
 rtl/prbs_descrambler.sv | 186 ++++++++++++++++++
 tb/tb_prbs_descrambler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_descrambler.sv
// Frame-synchronous PRBS descrambler: hunts for the sync byte, confirms frame
// alignment, then XORs each data byte with a 15-bit LFSR keystream reloaded at every sync.
module prbs_descrambler #(
  parameter int unsigned FRAME_LEN  = 188,
  parameter logic [7:0]  SYNC_BYTE  = 8'h47,
  parameter logic [14:0] SEED       = 15'b000000010101001,
  parameter int unsigned CONFIRM    = 3,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        lock,
  output logic [14:0] lfsr_state
);

  localparam int unsigned POS_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned CNT_MAX = (CONFIRM > MISS_LIMIT) ? CONFIRM : MISS_LIMIT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 2);

  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRAME_LEN - 1);
  localparam logic [POS_W-1:0] POS_AFTER = (FRAME_LEN > 1) ? POS_W'(1) : '0;
  localparam logic [CNT_W-1:0] CONFIRM_N = CNT_W'(CONFIRM);
  localparam logic [CNT_W-1:0] MISS_N    = CNT_W'(MISS_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {ST_HUNT, ST_CONFIRM, ST_LOCKED} state_e;

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [14:0]      lfsr_q, lfsr_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_sof_q, out_sof_d;
  logic             lock_q, lock_d;

  logic [7:0]       ks_c;
  logic [14:0]      lfsr_adv_c;
  logic             accept_c;
  logic             at_sync_c;
  logic             is_sync_c;
  logic [POS_W-1:0] pos_inc_c;
  logic [CNT_W-1:0] sync_inc_c;
  logic [CNT_W-1:0] miss_inc_c;

  // Eight LFSR steps; the first keystream bit lands in bit 7.
  function automatic logic [22:0] lfsr_byte(input logic [14:0] s_in);
    logic [14:0] s;
    logic [7:0]  ks;
    logic        fb;
    s  = s_in;
    ks = '0;
    for (int i = 0; i < 8; i++) begin
      fb = s[14] ^ s[13];
      ks = {ks[6:0], fb};
      s  = {s[13:0], fb};
    end
    return {ks, s};
  endfunction

  assign {ks_c, lfsr_adv_c} = lfsr_byte(lfsr_q);

  assign in_ready   = out_ready | ~out_valid_q;
  assign accept_c   = in_valid & in_ready;
  assign at_sync_c  = (pos_q == '0);
  assign is_sync_c  = (in_data == SYNC_BYTE);
  assign pos_inc_c  = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
  assign sync_inc_c = sync_cnt_q + CNT_ONE;
  assign miss_inc_c = miss_cnt_q + CNT_ONE;

  // Alignment FSM, keystream update and output register loading.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    sync_cnt_d  = sync_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;

    if (accept_c) begin
      unique case (state_q)
        ST_HUNT: begin
          if (is_sync_c) begin
            state_d    = (CONFIRM_N <= CNT_ONE) ? ST_LOCKED : ST_CONFIRM;
            pos_d      = POS_AFTER;
            sync_cnt_d = CNT_ONE;
            miss_cnt_d = '0;
            lfsr_d     = SEED;
          end
        end
        ST_CONFIRM: begin
          if (at_sync_c) begin
            if (is_sync_c) begin
              sync_cnt_d = sync_inc_c;
              lfsr_d     = SEED;
              pos_d      = pos_inc_c;
              if (sync_inc_c >= CONFIRM_N) begin
                state_d    = ST_LOCKED;
                miss_cnt_d = '0;
              end
            end else begin
              // A non-sync byte can never start a new HUNT, so it is simply dropped.
              state_d    = ST_HUNT;
              pos_d      = '0;
              sync_cnt_d = '0;
            end
          end else begin
            lfsr_d = lfsr_adv_c;
            pos_d  = pos_inc_c;
          end
        end
        ST_LOCKED: begin
          if (at_sync_c) begin
            if (!is_sync_c && (miss_inc_c >= MISS_N)) begin
              state_d    = ST_HUNT;
              pos_d      = '0;
              sync_cnt_d = '0;
              miss_cnt_d = '0;
              lfsr_d     = SEED;
            end else begin
              miss_cnt_d  = is_sync_c ? '0 : miss_inc_c;
              lfsr_d      = SEED;
              pos_d       = pos_inc_c;
              out_valid_d = 1'b1;
              out_data_d  = in_data;
              out_sof_d   = 1'b1;
            end
          end else begin
            lfsr_d      = lfsr_adv_c;
            pos_d       = pos_inc_c;
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ ks_c;
            out_sof_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_HUNT;
          pos_d   = '0;
        end
      endcase
    end

    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HUNT;
      pos_q       <= '0;
      sync_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      lfsr_q      <= SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      sync_cnt_q  <= sync_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      lock_q      <= lock_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sof    = out_sof_q;
  assign lock       = lock_q;
  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_prbs_descrambler.sv
// Bench for prbs_descrambler: scrambles random plaintext with its own LFSR, feeds the
// frames in, and checks descrambled output, alignment and reset through a scoreboard.
module tb_prbs_descrambler;

  localparam logic [14:0] SEED_M   = 15'h00A9;
  localparam int unsigned FLEN     = 188;
  localparam logic [7:0]  BAD_SYNC = 8'hB8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        lock;
  logic [14:0] lfsr_state;

  int          n_cmp;
  int          n_err;
  logic [8:0]  exp_q[$];
  logic [14:0] lfsr_m;
  logic [8:0]  held;
  bit          held_vld;

  prbs_descrambler dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .lock       (lock),
    .lfsr_state (lfsr_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Keystream byte from the bench LFSR: fb = s14^s13, shifted in at s0, MSB first.
  task automatic next_ks(output logic [7:0] ks);
    logic fb;
    ks = '0;
    for (int i = 0; i < 8; i++) begin
      fb     = lfsr_m[14] ^ lfsr_m[13];
      ks     = {ks[6:0], fb};
      lfsr_m = {lfsr_m[13:0], fb};
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_out, input logic [7:0] exp_d,
                           input bit exp_sof);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("send_accept", 32'(acc), 32'd1);
    else if (exp_out) exp_q.push_back({exp_sof, exp_d});
  endtask

  task automatic send_sync(input logic [7:0] b, input bit exp_out);
    lfsr_m = SEED_M;
    send_byte(b, exp_out, b, 1'b1);
  endtask

  task automatic send_data(input bit exp_out);
    logic [7:0] p;
    logic [7:0] ks;
    p = 8'($urandom);
    next_ks(ks);
    send_byte(p ^ ks, exp_out, p, 1'b0);
  endtask

  task automatic send_payload(input int n, input bit exp_out);
    for (int i = 0; i < n; i++) send_data(exp_out);
  endtask

  // Scoreboard: a byte is transferred at the posedge following a negedge with valid&ready.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      held_vld = 1'b0;
      if (exp_q.size() == 0) begin
        check("unexpected_output", {23'd0, out_sof, out_data}, 32'h1FF);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[7:0]));
        check("out_sof", 32'(out_sof), 32'(e[8]));
      end
    end else if (rst && out_valid) begin
      if (held_vld) check("stall_hold", 32'({out_sof, out_data}), 32'(held));
      held     = {out_sof, out_data};
      held_vld = 1'b1;
    end else begin
      held_vld = 1'b0;
    end
  end

  initial begin
    logic [7:0] p;
    logic [7:0] ks;
    logic [7:0] c;

    n_cmp     = 0;
    n_err     = 0;
    held_vld  = 1'b0;
    lfsr_m    = SEED_M;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_lock", 32'(lock), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sof", 32'(out_sof), 32'd0);
    check("rst_lfsr", 32'(lfsr_state), 32'h00A9);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // False sync in HUNT, then a wrong byte at pos 0 sends the FSM back to HUNT
    for (int i = 0; i < 5; i++) send_byte(8'h00, 1'b0, 8'h00, 1'b0);
    send_byte(8'h47, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < FLEN - 1; i++) send_byte(8'h00, 1'b0, 8'h00, 1'b0);
    send_byte(8'h5A, 1'b0, 8'h00, 1'b0);
    check("false_sync_lock", 32'(lock), 32'd0);

    // Acquisition: lock must rise on the third sync, not the second
    send_sync(8'h47, 1'b0);
    check("acq_lock_sync1", 32'(lock), 32'd0);
    send_payload(FLEN - 1, 1'b0);
    send_sync(8'h47, 1'b0);
    check("acq_lock_sync2", 32'(lock), 32'd0);
    send_payload(FLEN - 1, 1'b0);
    send_sync(8'h47, 1'b0);
    check("acq_lock_sync3", 32'(lock), 32'd1);
    send_payload(FLEN - 1, 1'b1);

    // Known-answer keystream after a locked sync
    send_sync(8'h47, 1'b1);
    check("kat_lfsr_seed", 32'(lfsr_state), 32'h00A9);
    send_byte(8'h00, 1'b1, 8'h03, 1'b0);
    send_byte(8'h00, 1'b1, 8'hF6, 1'b0);
    next_ks(ks);
    next_ks(ks);
    check("kat_lfsr_adv", 32'(lfsr_state), 32'(lfsr_m));
    send_payload(FLEN - 3, 1'b1);

    // Backpressure: five stalled cycles with a byte waiting at the input
    send_sync(8'h47, 1'b1);
    send_payload(10, 1'b1);
    p = 8'($urandom);
    next_ks(ks);
    c = p ^ ks;
    in_valid  = 1'b1;
    in_data   = c;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_byte(c, 1'b1, p, 1'b0);
    send_payload(FLEN - 12, 1'b1);

    // Loss of lock: single miss tolerated, good sync clears, two misses drop
    send_sync(BAD_SYNC, 1'b1);
    check("miss1_lock", 32'(lock), 32'd1);
    check("miss1_lfsr_reload", 32'(lfsr_state), 32'h00A9);
    send_payload(FLEN - 1, 1'b1);
    send_sync(8'h47, 1'b1);
    send_payload(FLEN - 1, 1'b1);
    send_sync(BAD_SYNC, 1'b1);
    check("miss2a_lock", 32'(lock), 32'd1);
    send_payload(FLEN - 1, 1'b1);
    send_sync(BAD_SYNC, 1'b0);
    check("miss2b_lock", 32'(lock), 32'd0);

    // Re-lock, then reset mid-frame with a byte pending at the output
    send_sync(8'h47, 1'b0);
    send_payload(FLEN - 1, 1'b0);
    send_sync(8'h47, 1'b0);
    send_payload(FLEN - 1, 1'b0);
    send_sync(8'h47, 1'b0);
    check("relock_lock", 32'(lock), 32'd1);
    send_payload(3, 1'b1);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_lock", 32'(lock), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_lfsr", 32'(lfsr_state), 32'h00A9);
    check("mid_rst_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_byte(8'h11, 1'b0, 8'h00, 1'b0);
    send_byte(8'h22, 1'b0, 8'h00, 1'b0);
    send_byte(8'h33, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_lock", 32'(lock), 32'd0);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
